// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - Request/response handshake bundle for seq_alu
// Ports (signals):
//   in_valid/in_ready       request handshake
//   alu_a/alu_b/alu_sel     operands and operation code
//   out_valid/out_ready     result handshake
//   alu_out                 registered result
//   busy                    iterative operation in progress
// Modports: master = core side (issues ops, consumes results), slave = seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             busy;

  modport master (
    output in_valid, alu_a, alu_b, alu_sel, out_ready,
    input  in_ready, out_valid, alu_out, busy
  );

  modport slave (
    input  in_valid, alu_a, alu_b, alu_sel, out_ready,
    output in_ready, out_valid, alu_out, busy
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - Handshaked ALU with iterative RV32M multiply/divide/remainder
// Optional feature macro: SEQ_ALU_FAST_SPECIAL_EN (1-cycle divide-by-zero,
// signed-overflow divide/remainder and multiply-by-zero).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_alu_if.slave: in_valid/in_ready/alu_a/alu_b/alu_sel request,
//          out_valid/out_ready/alu_out result, busy status
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;

  localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_AND  = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_OR   = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_XOR  = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_SLL  = SEL_W'(5);
  localparam logic [SEL_W-1:0] OP_SLT  = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_SLTU = SEL_W'(7);
  localparam logic [SEL_W-1:0] OP_SRA  = SEL_W'(8);
  localparam logic [SEL_W-1:0] OP_SRL  = SEL_W'(9);
  localparam logic [SEL_W-1:0] OP_PASS = SEL_W'(10);
  localparam logic [SEL_W-1:0] OP_CSR  = SEL_W'(11);
  localparam logic [SEL_W-1:0] OP_MUL  = SEL_W'(16);
  localparam logic [SEL_W-1:0] OP_REMU = SEL_W'(23);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;      // product accumulator; low half doubles as dividend/quotient
  logic [WIDTH:0]     rem_q;    // partial remainder for the trial subtract
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic [2:0]         op_q;     // low bits of the iterative op code
  logic               neg_q;    // negate product / quotient at FIX
  logic               neg_r;    // negate remainder at FIX
  logic               out_valid_q;
  logic               busy_q;
  logic [WIDTH-1:0]   alu_out_q;

  logic             in_ready_w;
  logic             accept;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] sc_res;
  logic [2:0]       sel_lo;
  logic             is_iter;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             fast_hit;
  logic [WIDTH-1:0] fast_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] fix_res;

  assign in_ready_w    = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && in_ready_w;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_out   = alu_out_q;
  assign bus.busy      = busy_q;

  assign shamt   = bus.alu_b[SH_W-1:0];
  assign sel_lo  = bus.alu_sel[2:0];
  assign is_iter = (bus.alu_sel >= OP_MUL) && (bus.alu_sel <= OP_REMU);

  // Codes 16..23: operand A is signed for MUL/MULH/MULHSU/DIV/REM,
  // operand B for MUL/MULH/DIV/REM.
  assign sign_a = (sel_lo inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6}) && bus.alu_a[WIDTH-1];
  assign sign_b = (sel_lo inside {3'd0, 3'd1, 3'd4, 3'd6}) && bus.alu_b[WIDTH-1];
  assign mag_a  = sign_a ? -bus.alu_a : bus.alu_a;
  assign mag_b  = sign_b ? -bus.alu_b : bus.alu_b;

  always_comb begin
    sc_res = '0;
    case (bus.alu_sel)
      OP_ADD:  sc_res = bus.alu_a + bus.alu_b;
      OP_SUB:  sc_res = bus.alu_a - bus.alu_b;
      OP_AND:  sc_res = bus.alu_a & bus.alu_b;
      OP_OR:   sc_res = bus.alu_a | bus.alu_b;
      OP_XOR:  sc_res = bus.alu_a ^ bus.alu_b;
      OP_SLL:  sc_res = bus.alu_a << shamt;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.alu_a) < $signed(bus.alu_b)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, bus.alu_a < bus.alu_b};
      OP_SRA:  sc_res = $unsigned($signed(bus.alu_a) >>> shamt);
      OP_SRL:  sc_res = bus.alu_a >> shamt;
      OP_PASS: sc_res = bus.alu_b;
      OP_CSR:  sc_res = bus.alu_a;
      default: sc_res = '0;
    endcase
  end

`ifdef SEQ_ALU_FAST_SPECIAL_EN
  logic b_zero;
  logic div_ovf;
  always_comb begin
    b_zero   = (bus.alu_b == '0);
    div_ovf  = (sel_lo == 3'd4 || sel_lo == 3'd6) &&
               (bus.alu_a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.alu_b == '1);
    fast_hit = 1'b0;
    fast_res = '0;
    if (!sel_lo[2]) begin
      fast_hit = b_zero;                              // MUL* by zero -> 0
    end else if (b_zero) begin
      fast_hit = 1'b1;
      fast_res = sel_lo[1] ? bus.alu_a : '1;          // REM* -> A, DIV* -> all ones
    end else if (div_ovf) begin
      fast_hit = 1'b1;
      fast_res = sel_lo[1] ? '0 : bus.alu_a;          // REM -> 0, DIV -> A
    end
  end
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // One shift-add step (multiply) or one restoring trial subtract (divide).
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  assign div_shift = {rem_q[WIDTH-1:0], acc[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_diff  = div_shift - {1'b0, opnd};

  // Division by zero leaves an all-ones quotient magnitude; neg_q is cleared for
  // it at accept so the quotient stays all ones. The remainder magnitude is |A|,
  // so restoring A's sign yields REM = A without extra logic.
  always_comb begin
    prod    = neg_q ? -acc : acc;
    quo     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fix_res = '0;
    case (op_q)
      3'd0:             fix_res = prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       fix_res = quo;
      default:          fix_res = WIDTH'(neg_r ? -rem_q : rem_q);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      rem_q       <= '0;
      opnd        <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      alu_out_q   <= '0;
    end else begin
      if (bus.out_ready) out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_iter || fast_hit) begin
              alu_out_q   <= is_iter ? fast_res : sc_res;
              out_valid_q <= 1'b1;
            end else begin
              op_q   <= sel_lo;
              neg_q  <= (sign_a ^ sign_b) && (bus.alu_b != '0);
              neg_r  <= sign_a;
              opnd   <= sel_lo[2] ? mag_b : mag_a;
              acc    <= {{WIDTH{1'b0}}, sel_lo[2] ? mag_a : mag_b};
              rem_q  <= '0;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= ITER;
            end
          end
        end
        ITER: begin
          if (!op_q[2]) begin
            if (acc[0]) acc <= {mul_sum, acc[WIDTH-1:1]};
            else        acc <= {1'b0, acc[2*WIDTH-1:1]};
          end else begin
            rem_q           <= div_ge ? div_diff : div_shift;
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          alu_out_q   <= fix_res;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          cnt         <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - Self-checking bench for seq_alu (WIDTH=32)
module tb_seq_alu;
  localparam int W = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;
`ifdef SEQ_ALU_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  seq_alu_if #(.WIDTH(W), .SEL_W(5)) bus ();
  seq_alu #(.WIDTH(W), .SEL_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain arithmetic on the RISC-V definitions.
  function automatic logic [31:0] ref_result(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint pa;
    logic [63:0] up;
    bit ovf;
    sa = a; sb = b;
    ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
    case (sel)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return {31'b0, sa < sb};
      5'd7:  return {31'b0, a < b};
      5'd8:  return 32'(sa >>> b[4:0]);
      5'd9:  return a >> b[4:0];
      5'd10: return b;
      5'd11: return a;
      5'd16: begin pa = longint'(sa) * longint'(sb); return pa[31:0]; end
      5'd17: begin pa = longint'(sa) * longint'(sb); return pa[63:32]; end
      5'd18: begin pa = longint'(sa) * longint'({32'b0, b}); return pa[63:32]; end
      5'd19: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      5'd20: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      5'd23: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Edges after the accept edge until out_valid is seen high.
  function automatic int ref_edges(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    bit special;
    if (sel < 5'd16 || sel > 5'd23) return 0;
    special = (b == 0) || ((sel == 5'd20 || sel == 5'd22) && a == MINV && b == 32'hFFFF_FFFF);
    return (FAST && special) ? 0 : W + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MINV;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op with out_ready=1; edges=-1 if it is never accepted.
  task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int edges);
    int guard;
    @(negedge clk);
    bus.alu_sel = sel; bus.alu_a = a; bus.alu_b = b;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin @(negedge clk); #1; guard++; end
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0; edges = -1; res = bus.alu_out;
    end else begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      edges = 0;
      while (!bus.out_valid && edges < 100) begin @(posedge clk); #1; edges++; end
      res = bus.alu_out;
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.alu_a = '0; bus.alu_b = '0; bus.alu_sel = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", bus.busy); end
    checks++; if (bus.alu_out !== 32'h0) begin failures++; $display("FAIL reset alu_out got=%h exp=0", bus.alu_out); end
  endtask

  task automatic test_single();
    logic [4:0]  s [9] = '{5'd0, 5'd8, 5'd13, 5'd6, 5'd7, 5'd5, 5'd10, 5'd11, 5'd9};
    logic [31:0] a [9] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                           32'h1, 32'hAAAA, 32'hAAAA, 32'h8000_0000};
    logic [31:0] b [9] = '{32'h1, 32'h4, 32'h9ABC_DEF0, 32'h1, 32'h1, 32'h3F, 32'h5555, 32'h5555, 32'h4};
    logic [31:0] e [9] = '{32'h8000_0000, 32'hF800_0000, 32'h0, 32'h1, 32'h0, 32'h8000_0000,
                           32'h5555, 32'hAAAA, 32'h0800_0000};
    logic [31:0] res;
    int edges;
    for (int i = 0; i < 9; i++) begin
      run_op(s[i], a[i], b[i], res, edges);
      checks++; if (res !== e[i]) begin failures++; $display("FAIL single[%0d] sel=%0d got=%h exp=%h", i, s[i], res, e[i]); end
      checks++; if (edges !== 0) begin failures++; $display("FAIL single_lat[%0d] got=%0d exp=0", i, edges); end
    end
  endtask

  task automatic test_iter_directed();
    logic [4:0]  s [14] = '{5'd17, 5'd16, 5'd19, 5'd18, 5'd16, 5'd20, 5'd22, 5'd21, 5'd23,
                            5'd20, 5'd22, 5'd20, 5'd22, 5'd21};
    logic [31:0] a [14] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234,
                            32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h5, 32'h5, MINV, MINV,
                            32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100};
    logic [31:0] b [14] = '{32'h3, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h2, 32'h2, 32'h0,
                            32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'd7};
    logic [31:0] e [14] = '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0,
                            32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, MINV, 32'h0,
                            32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd14};
    bit          sp [14] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    logic [31:0] res;
    int edges, exp_edges;
    for (int i = 0; i < 14; i++) begin
      run_op(s[i], a[i], b[i], res, edges);
      exp_edges = (FAST && sp[i]) ? 0 : W + 1;
      checks++; if (res !== e[i]) begin failures++; $display("FAIL iter[%0d] sel=%0d got=%h exp=%h", i, s[i], res, e[i]); end
      checks++; if (edges !== exp_edges) begin failures++; $display("FAIL iter_lat[%0d] got=%0d exp=%0d", i, edges, exp_edges); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] add_exp, sub_exp;
    add_exp = 32'h0000_1111 + 32'h0000_2222;
    sub_exp = 32'h0000_0010 - 32'h0000_0020;
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.alu_sel = 5'd0; bus.alu_a = 32'h1111; bus.alu_b = 32'h2222;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.alu_sel = 5'd1; bus.alu_a = 32'h10; bus.alu_b = 32'h20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.alu_out} !== {1'b1, 1'b0, add_exp}) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b r=%b out=%h exp v=1 r=0 out=%h", i, bus.out_valid, bus.in_ready, bus.alu_out, add_exp);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.alu_out} !== {1'b1, sub_exp}) begin
      failures++;
      $display("FAIL bp_b2b got v=%b out=%h exp v=1 out=%h", bus.out_valid, bus.alu_out, sub_exp);
    end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_iter();
    logic [31:0] res;
    int edges, stray;
    run_op(5'd0, 32'd5, 32'd6, res, edges);
    checks++; if (res !== 32'd11) begin failures++; $display("FAIL rst_pre got=%h exp=%h", res, 32'd11); end
    @(negedge clk);
    bus.alu_sel = 5'd16; bus.alu_a = $urandom | 32'h1; bus.alu_b = $urandom | 32'h1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rst_busy_before got=%b exp=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.alu_out} !== {1'b0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL rst_async got v=%b busy=%b out=%h exp v=0 busy=0 out=0", bus.out_valid, bus.busy, bus.alu_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", bus.in_ready); end
    run_op(5'd0, 32'd2, 32'd2, res, edges);
    checks++; if (res !== 32'd4) begin failures++; $display("FAIL rst_add got=%h exp=4", res); end
    checks++; if (edges !== 0) begin failures++; $display("FAIL rst_add_lat got=%0d exp=0", edges); end
    stray = 0;
    @(posedge clk);
    repeat (40) begin @(negedge clk); if (bus.out_valid) stray++; end
    checks++; if (stray !== 0) begin failures++; $display("FAIL rst_no_stray got=%0d exp=0", stray); end
  endtask

  task automatic test_busy_hold();
    logic [31:0] a, b, exp;
    int waits, extra, idle_busy, seen, stray;
    a = $urandom; b = 32'($urandom_range(1, 1000));
    exp = a / b;
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.alu_sel = 5'd21; bus.alu_a = a; bus.alu_b = b; bus.in_valid = 1'b1;
    @(posedge clk);
    waits = 0; extra = 0; idle_busy = 0; seen = 0;
    while (waits < 60) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1; break; end
      if (bus.in_ready) extra++;
      if (!bus.busy) idle_busy++;
      waits++;
    end
    bus.in_valid = 1'b0;
    checks++; if (seen !== 1) begin failures++; $display("FAIL hold_result_seen got=%0d exp=1", seen); end
    checks++; if (bus.alu_out !== exp) begin failures++; $display("FAIL hold_result got=%h exp=%h", bus.alu_out, exp); end
    checks++; if (waits !== W + 1) begin failures++; $display("FAIL hold_lat got=%0d exp=%0d", waits, W + 1); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL hold_in_ready_high got=%0d exp=0", extra); end
    checks++; if (idle_busy !== 0) begin failures++; $display("FAIL hold_busy_low got=%0d exp=0", idle_busy); end
    stray = 0;
    @(posedge clk);
    repeat (40) begin @(negedge clk); if (bus.out_valid) stray++; end
    checks++; if (stray !== 0) begin failures++; $display("FAIL hold_one_result got=%0d exp=0", stray); end
  endtask

  task automatic test_random();
    logic [4:0] sel;
    logic [31:0] a, b, res, exp;
    int edges, exp_edges;
    for (int i = 0; i < 40; i++) begin
      sel = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(16, 23)) : 5'($urandom_range(0, 31));
      a = pick_operand();
      b = pick_operand();
      exp = ref_result(sel, a, b);
      exp_edges = ref_edges(sel, a, b);
      run_op(sel, a, b, res, edges);
      checks++;
      if (res !== exp) begin
        failures++;
        $display("FAIL rand[%0d] sel=%0d a=%h b=%h got=%h exp=%h", i, sel, a, b, res, exp);
      end
      checks++; if (edges !== exp_edges) begin failures++; $display("FAIL rand_lat[%0d] sel=%0d got=%0d exp=%0d", i, sel, edges, exp_edges); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_iter_directed();
    test_backpressure();
    test_reset_mid_iter();
    test_busy_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
